// File: rtl/rv32i_pkg.sv
// Shared rv32i encodings used by the writeback stage.
package rv32i_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_LOAD = 2'd1,
    ST_WRITE     = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_extend.sv
// Combinational load lane select and size/sign extension of an aligned memory word.
module load_extend
  import rv32i_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign shifted   = raw >> {addr_lo, 3'b000};
  assign byte_lane = shifted[7:0];
  // Halfwords ignore addr_lo[0]; misalignment is trapped before this stage.
  assign half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      F3_LH:   data = {{16{half_lane[15]}}, half_lane};
      F3_LBU:  data = {24'h0, byte_lane};
      F3_LHU:  data = {16'h0, half_lane};
      F3_LW:   data = raw;
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: sole writer of the register file; waits for load data, times out
// abandoned loads, and presents each write for exactly one registered cycle.
module wb_stage
  import rv32i_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_wb_sel,
  input  logic [31:0] in_alu,
  input  logic [31:0] in_pc4,
  input  logic [2:0]  in_funct3,
  input  logic [1:0]  in_addr_lo,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        wrt_en,
  output logic [4:0]  oprd,
  output logic [31:0] wrt_data,
  output logic        load_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  wb_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [4:0]       rd_q, rd_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       lo_q, lo_d;
  logic             wen_d, err_d;
  logic [4:0]       oprd_d;
  logic [31:0]      data_d;
  logic [31:0]      ext_data;

  load_extend u_ext (
    .funct3  (f3_q),
    .addr_lo (lo_q),
    .raw     (mem_rsp_data),
    .data    (ext_data)
  );

  assign in_ready = (state != ST_WAIT_LOAD);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rd_d    = rd_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    wen_d   = 1'b0;
    err_d   = 1'b0;
    oprd_d  = oprd;
    data_d  = wrt_data;
    case (state)
      ST_IDLE, ST_WRITE: begin
        if (in_valid) begin
          if (in_wb_sel == WB_LOAD) begin
            state_d = ST_WAIT_LOAD;
            cnt_d   = '0;
            rd_d    = in_rd;
            f3_d    = in_funct3;
            lo_d    = in_addr_lo;
          end else begin
            state_d = ST_WRITE;
            wen_d   = (in_wb_sel != WB_NONE) && (in_rd != 5'd0);
            oprd_d  = in_rd;
            data_d  = (in_wb_sel == WB_PC4) ? in_pc4 : in_alu;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_LOAD: begin
        if (mem_rsp_valid) begin
          state_d = ST_WRITE;
          wen_d   = (rd_q != 5'd0);
          oprd_d  = rd_q;
          data_d  = ext_data;
        end else if (cnt == CNT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      rd_q     <= 5'd0;
      f3_q     <= 3'd0;
      lo_q     <= 2'd0;
      wrt_en   <= 1'b0;
      oprd     <= 5'd0;
      wrt_data <= 32'd0;
      load_err <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      rd_q     <= rd_d;
      f3_q     <= f3_d;
      lo_q     <= lo_d;
      wrt_en   <= wen_d;
      oprd     <= oprd_d;
      wrt_data <= data_d;
      load_err <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/PC4 writes, loads with extension, x0 suppression,
// timeout and reset-abandoned loads.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc4;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        wrt_en;
  logic [4:0]  oprd;
  logic [31:0] wrt_data;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_stage #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu        (in_alu),
    .in_pc4        (in_pc4),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .wrt_en        (wrt_en),
    .oprd          (oprd),
    .wrt_data      (wrt_data),
    .load_err      (load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled only on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid      = 1'b0;
    in_rd         = 5'd0;
    in_wb_sel     = 2'd0;
    in_alu        = 32'd0;
    in_pc4        = 32'd0;
    in_funct3     = 3'd0;
    in_addr_lo    = 2'd0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
  endtask

  // Load to rd 7; a same-cycle response is offered and must be ignored.
  // The real response arrives 3 cycles after accept.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] lo,
                         input logic [31:0] raw, input logic [31:0] exp);
    in_valid      = 1'b1;
    in_wb_sel     = 2'd1;
    in_rd         = 5'd7;
    in_funct3     = f3;
    in_addr_lo    = lo;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hA5A5A5A5;
    tick();
    in_valid      = 1'b0;
    mem_rsp_valid = 1'b0;
    check({tag, " ready0 c1"}, {31'd0, in_ready}, 32'd0);
    check({tag, " no early wr"}, {31'd0, wrt_en}, 32'd0);
    tick();
    check({tag, " ready0 c2"}, {31'd0, in_ready}, 32'd0);
    tick();
    check({tag, " ready0 c3"}, {31'd0, in_ready}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = raw;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, " wrt_en"}, {31'd0, wrt_en}, 32'd1);
    check({tag, " oprd"}, {27'd0, oprd}, 32'd7);
    check({tag, " data"}, wrt_data, exp);
    check({tag, " ready1"}, {31'd0, in_ready}, 32'd1);
    tick();
    check({tag, " wr done"}, {31'd0, wrt_en}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check("rst wrt_en", {31'd0, wrt_en}, 32'd0);
    check("rst oprd", {27'd0, oprd}, 32'd0);
    check("rst data", wrt_data, 32'd0);
    check("rst load_err", {31'd0, load_err}, 32'd0);
    check("rst ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single ALU write then idle.
    in_valid = 1'b1; in_wb_sel = 2'd0; in_rd = 5'd5; in_alu = 32'hDEADBEEF;
    tick();
    in_valid = 1'b0;
    check("alu wrt_en", {31'd0, wrt_en}, 32'd1);
    check("alu oprd", {27'd0, oprd}, 32'd5);
    check("alu data", wrt_data, 32'hDEADBEEF);
    tick();
    check("alu after", {31'd0, wrt_en}, 32'd0);

    // Back-to-back ALU writes to rd 1..3.
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_wb_sel = 2'd0; in_rd = 5'(i); in_alu = 32'h1000 + 32'(i);
      check("b2b ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("b2b wrt_en", {31'd0, wrt_en}, 32'd1);
      check("b2b oprd", {27'd0, oprd}, 32'(i));
      check("b2b data", wrt_data, 32'h1000 + 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check("b2b end", {31'd0, wrt_en}, 32'd0);

    // PC+4 source.
    in_valid = 1'b1; in_wb_sel = 2'd2; in_rd = 5'd1; in_pc4 = 32'h0000_0208; in_alu = 32'h1;
    tick();
    in_valid = 1'b0;
    check("pc4 wrt_en", {31'd0, wrt_en}, 32'd1);
    check("pc4 data", wrt_data, 32'h0000_0208);
    // NONE never writes.
    in_valid = 1'b1; in_wb_sel = 2'd3; in_rd = 5'd4;
    tick();
    in_valid = 1'b0;
    check("none wrt_en", {31'd0, wrt_en}, 32'd0);
    tick();

    do_load("lb",  3'b000, 2'd2, 32'h00807F00, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 2'd2, 32'h00807F00, 32'h00000080);
    do_load("lhu", 3'b101, 2'd0, 32'h00807F00, 32'h00007F00);
    do_load("lh mis", 3'b001, 2'd3, 32'h80010000, 32'hFFFF8001);
    do_load("lb b3", 3'b000, 2'd3, 32'h7F000000, 32'h0000007F);
    do_load("f3 011", 3'b011, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);

    // Writes to x0 are suppressed for both JAL and LW.
    in_valid = 1'b1; in_wb_sel = 2'd2; in_rd = 5'd0; in_pc4 = 32'h104;
    tick();
    check("jal x0 wrt_en", {31'd0, wrt_en}, 32'd0);
    in_wb_sel = 2'd1; in_funct3 = 3'b010; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0;
    check("lw x0 ready0", {31'd0, in_ready}, 32'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234;
    tick();
    mem_rsp_valid = 1'b0;
    check("lw x0 wrt_en", {31'd0, wrt_en}, 32'd0);
    check("lw x0 ready1", {31'd0, in_ready}, 32'd1);
    tick();

    // Timeout with TIMEOUT=8: load_err 8 cycles after accept, no write.
    in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd9; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("to wait err", {31'd0, load_err}, 32'd0);
      check("to wait ready", {31'd0, in_ready}, 32'd0);
      check("to wait wr", {31'd0, wrt_en}, 32'd0);
    end
    tick();
    check("to err pulse", {31'd0, load_err}, 32'd1);
    check("to no wr", {31'd0, wrt_en}, 32'd0);
    check("to ready", {31'd0, in_ready}, 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h5555;
    tick();
    mem_rsp_valid = 1'b0;
    check("to err once", {31'd0, load_err}, 32'd0);
    check("late rsp ignored", {31'd0, wrt_en}, 32'd0);
    tick();

    // Reset while waiting abandons the load.
    in_valid = 1'b1; in_wb_sel = 2'd1; in_rd = 5'd10; in_funct3 = 3'b010;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst wrt_en", {31'd0, wrt_en}, 32'd0);
    check("mrst oprd", {27'd0, oprd}, 32'd0);
    check("mrst data", wrt_data, 32'd0);
    check("mrst err", {31'd0, load_err}, 32'd0);
    check("mrst ready", {31'd0, in_ready}, 32'd1);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h7777;
    tick();
    mem_rsp_valid = 1'b0;
    check("mrst rsp wr", {31'd0, wrt_en}, 32'd0);
    check("mrst rsp err", {31'd0, load_err}, 32'd0);
    check("mrst rsp ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
